// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared frame constants and sample-to-level conversion for the PWM DAC
package pwm_dac_pkg;
  localparam int DW = 8;
  localparam int FRAME = 256;
  localparam int OFFSET = 128;
  localparam int CW = $clog2(FRAME);
  function automatic logic [DW-1:0] to_level(input logic signed [DW-1:0] s);
    return {~s[DW-1], s[DW-2:0]};
  endfunction
endpackage

// File: rtl/pwm_dac_if.sv
// pwm_dac_if: sample stream in, ack strobe and PWM bitstream out
interface pwm_dac_if;
  import pwm_dac_pkg::*;
  logic signed [DW-1:0] din;
  logic din_ack;
  logic dacout;
  modport master (output din, input din_ack, dacout);
  modport slave (input din, output din_ack, dacout);
endinterface

// File: rtl/pwm_frame_counter.sv
// pwm_frame_counter: free-running frame counter with a one-cycle end-of-frame ack
module pwm_frame_counter
  import pwm_dac_pkg::*;
(
  input  logic          clk,
  input  logic          rst_an,
  output logic [CW-1:0] cnt,
  output logic          ack
);
  // ack is decoded one count early so the registered strobe lines up with the last count
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      cnt <= '0;
      ack <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      ack <= cnt == CW'(FRAME - 2);
    end
endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: captures one signed sample per frame and emits its offset-binary level as PWM
module pwm_dac #(
  parameter int DW = pwm_dac_pkg::DW
) (
  input logic      clk,
  input logic      rst_an,
  pwm_dac_if.slave bus
);
  import pwm_dac_pkg::*;
  logic [CW-1:0] cnt;
  logic          ack;
  logic [DW-1:0] level;
  pwm_frame_counter u_cnt (.clk(clk), .rst_an(rst_an), .cnt(cnt), .ack(ack));
  assign bus.din_ack = ack;
  // sampling one cycle after the ack gives upstream a full cycle to present the new sample
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      level <= DW'(OFFSET);
      bus.dacout <= 1'b0;
    end else begin
      if (cnt == '0) level <= to_level(bus.din);
      bus.dacout <= cnt < level;
    end
endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: random, constant and sine streams scored per frame against din+128
module tb_pwm_dac;
  logic clk = 1'b0;
  logic rst_an = 1'b0;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int edges = 0;
  int phase = 0;
  int sum = 0;
  bit a1 = 1'b0;
  bit a2 = 1'b0;
  int e;
  pwm_dac_if bus();
  pwm_dac dut (.clk(clk), .rst_an(rst_an), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // rising edges since reset release; cnt is this value modulo the frame length
  initial forever begin
    @(posedge clk or negedge rst_an);
    edges = rst_an ? edges + 1 : 0;
  end
  // a frame's duty shows on dacout two cycles late, so each window closes two cycles after an ack
  initial forever begin
    @(negedge clk or negedge rst_an);
    if (!rst_an) begin
      sum = 0;
      a1 = 1'b0;
      a2 = 1'b0;
    end else begin
      chk("ack_timing", int'(bus.din_ack), int'(edges % 256 == 255));
      if (edges >= 2) sum += int'(bus.dacout);
      if (a2) begin
        chk("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_high", sum, e);
        end
        sum = 0;
      end
      a2 = a1;
      a1 = bus.din_ack;
    end
  end
  function automatic int next_din(input int mode, input int val);
    if (mode == 0) return val;
    if (mode == 1) return int'($urandom_range(255, 0)) - 128;
    phase++;
    return $rtoi(127.0 * $sin(2.0 * 3.141592653589793 * phase / 256.0));
  endfunction
  task automatic wait_ack(input bit garble);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.din_ack) got = 1'b1;
      else if (garble) bus.din = 8'($urandom);
    end
    chk("ack_seen", int'(got), 1);
  endtask
  task automatic frames(input int n, input int mode, input int val, input bit garble);
    logic signed [7:0] d;
    for (int k = 0; k < n; k++) begin
      wait_ack(garble);
      @(posedge clk);
      #1;
      d = 8'(next_din(mode, val));
      bus.din = d;
      exp_q.push_back(int'(d) + 128);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input logic signed [7:0] d);
    rst_an = 1'b0;
    bus.din = d;
    #1;
    chk("rst_dacout", int'(bus.dacout), 0);
    chk("rst_ack", int'(bus.din_ack), 0);
    exp_q.delete();
    exp_q.push_back(int'(d) + 128);
    #2 rst_an = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset(8'sd0);
    frames(3, 0, 0, 1'b0);
    frames(2, 0, -128, 1'b0);
    frames(2, 0, 127, 1'b0);
    frames(4, 1, 0, 1'b0);
    frames(3, 0, 0, 1'b1);
    frames(3, 1, 0, 1'b1);
    frames(2, 0, 127, 1'b0);
    wait_ack(1'b0);
    repeat (101) @(posedge clk);
    #3;
    chk("pre_rst_dacout", int'(bus.dacout), 1);
    do_reset(8'sd50);
    frames(3, 1, 0, 1'b0);
    phase = 0;
    frames(256, 2, 0, 1'b0);
    wait_ack(1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
